fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the asynchronous FIFO between `NREQ` write-domain requesters. Each requester presents data with a valid/ready handshake; the arbiter grants one requester at a time for bursts of up to `MAX_BURST` beats and drives `winc`/`wdata` directly into the FIFO, stalling on `wfull`. It sits entirely in the write clock domain, in front of the FIFO write side.

---
 rtl/fifo_write_arbiter_pkg.sv | 13 +
 rtl/fifo_write_arbiter_if.sv | 30 +++
 rtl/fifo_write_arbiter_rr_picker.sv | 27 ++
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_e;

   localparam int unsigned DEFAULT_MAX_BURST = 4;

   // Counter/index width that never collapses to zero bits.
   function automatic int unsigned cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake plus FIFO write-side signals of the write arbiter.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DATA = 8
) ();

   localparam int unsigned IDW = cw(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DATA-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 wfull;
   logic                 winc;
   logic [DATA-1:0]      wdata;
   logic [IDW-1:0]       grant_id;
   logic                 busy;

   modport master (
      input  req_valid, req_data, wfull,
      output req_ready, winc, wdata, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, wfull,
      input  req_ready, winc, wdata, grant_id, busy
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after base_id, wrapping.
module rr_picker #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  base_id,
   output logic            found,
   output logic [IDW-1:0]  pick_id
);

   always_comb begin
      int unsigned idx;
      idx     = 0;
      found   = 1'b0;
      pick_id = '0;
      // Offset NREQ lands back on base_id itself, so it is the last candidate.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(base_id) + k) % NREQ;
         if (!found && req[IDW'(idx)]) begin
            found   = 1'b1;
            pick_id = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter driving the async FIFO write port from NREQ requesters.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DATA      = 8,
   parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic                 wclk,
   input  logic                 wrstn,
   fifo_write_arbiter_if.master bus
);

   localparam int unsigned IDW = cw(NREQ);
   localparam int unsigned CW  = cw(MAX_BURST + 1);

   arb_state_e      state, next_state;
   logic [IDW-1:0]  grant_id, last_id, base_id, pick_id;
   logic [CW-1:0]   beat_cnt;
   logic            found, end_grant, winc_c, gvalid;
   logic [DATA-1:0] gdata, wdata_c;
   logic [NREQ-1:0] ready_c;
   logic [DATA-1:0] rdata [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign rdata[g] = bus.req_data[g*DATA +: DATA];
   end

   assign gvalid = bus.req_valid[grant_id];
   assign gdata  = rdata[grant_id];

   // The same picker serves IDLE entry and end-of-grant hand-over.
   assign base_id = (state == GRANT) ? grant_id : last_id;

   rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req     (bus.req_valid),
      .base_id (base_id),
      .found   (found),
      .pick_id (pick_id)
   );

   always_comb begin
      next_state = state;
      ready_c    = '0;
      winc_c     = 1'b0;
      wdata_c    = '0;
      end_grant  = 1'b0;
      case (state)
         IDLE: begin
            if (found) next_state = GRANT;
         end
         GRANT: begin
            ready_c[grant_id] = !bus.wfull;
            winc_c            = gvalid && !bus.wfull;
            if (winc_c) wdata_c = gdata;
            end_grant = (winc_c && beat_cnt == CW'(MAX_BURST - 1)) || !gvalid;
            if (end_grant && !found) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrstn) begin
      if (!wrstn) begin
         state    <= IDLE;
         grant_id <= '0;
         last_id  <= IDW'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= pick_id;
                  beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (end_grant) begin
                  last_id  <= grant_id;
                  beat_cnt <= '0;
                  if (found) grant_id <= pick_id;
               end else if (winc_c) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.winc      = winc_c;
   assign bus.wdata     = wdata_c;
   assign bus.grant_id  = grant_id;
   assign bus.busy      = (state == GRANT);

endmodule
